// File: rtl/mem_pkg.sv
// Shared types and constants for the guess path: presenter state encoding,
// LFSR polynomial and the default pattern width used by all three blocks.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      DONE = 2'd3
   } pattern_state_t;

   // x^16 + x^14 + x^13 + x^11 + 1 expressed as state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam int          DEFAULT_PATTERN_W = 16;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step whenever step is high.
module lfsr16
   import mem_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // next-state: hold unless stepping
   always_comb begin
      state_d = state_q;
      if (step) begin
         state_d = lfsr_next(state_q);
      end else begin
         state_d = state_q;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/pattern_player.sv
// Presents the round pattern MSB-first as timed LED pulses and publishes the
// masked pattern to the comparator; four-phase handshake on gen_pattern.
module pattern_player
   import mem_pkg::*;
#(
   parameter int          PATTERN_W  = DEFAULT_PATTERN_W,
   parameter int          ON_CYCLES  = 4,
   parameter int          OFF_CYCLES = 2,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        gen_pattern,
   input  logic [15:0] count,
   output logic        led,
   output logic        led_valid,
   output logic [15:0] game_pattern,
   output logic        done_gen_pattern,
   output logic        busy
);

   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);

   pattern_state_t state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [3:0]     idx_q, idx_d;
   logic [15:0]    seq_q, seq_d;
   logic [15:0]    gp_q, gp_d;
   logic           led_q, led_d;
   logic           led_valid_q, led_valid_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic [15:0]    lfsr_state_s;
   logic [15:0]    len_s;
   logic [15:0]    mask_s;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  (clr),
      .state (lfsr_state_s)
   );

   // clamp requested length and build its low-bit mask
   always_comb begin
      len_s  = (count > 16'(PATTERN_W)) ? 16'(PATTERN_W) : count;
      mask_s = (len_s >= 16'd16) ? 16'hFFFF : ((16'd1 << len_s) - 16'd1);
   end

   // next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + TW'(1);
      idx_d   = idx_q;
      seq_d   = seq_q;
      gp_d    = gp_q;
      if (clr) begin
         state_d = IDLE;
         timer_d = '0;
         seq_d   = lfsr_next(lfsr_state_s);
      end else begin
         case (state_q)
            IDLE: begin
               timer_d = '0;
               if (gen_pattern && (len_s != 16'd0)) begin
                  state_d = ON;
                  idx_d   = 4'(len_s - 16'd1);
                  gp_d    = seq_q & mask_s;
               end else if (gen_pattern) begin
                  state_d = DONE;
                  gp_d    = 16'd0;
               end else begin
                  state_d = IDLE;
               end
            end
            ON: begin
               if (!gen_pattern) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == TW'(ON_CYCLES - 1)) begin
                  state_d = OFF;
                  timer_d = '0;
               end else begin
                  state_d = ON;
               end
            end
            OFF: begin
               if (!gen_pattern) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (timer_q == TW'(OFF_CYCLES - 1)) begin
                  timer_d = '0;
                  if (idx_q == 4'd0) begin
                     state_d = DONE;
                  end else begin
                     state_d = ON;
                     idx_d   = idx_q - 4'd1;
                  end
               end else begin
                  state_d = OFF;
               end
            end
            DONE: begin
               timer_d = '0;
               if (!gen_pattern) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
      led_valid_d = (state_d == ON);
      led_d       = (state_d == ON) ? seq_d[idx_d] : 1'b0;
      done_d      = (state_d == DONE);
      busy_d      = (state_d == ON) || (state_d == OFF);
   end

   // state, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         idx_q       <= 4'd0;
         seq_q       <= SEED;
         gp_q        <= 16'd0;
         led_q       <= 1'b0;
         led_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         seq_q       <= seq_d;
         gp_q        <= gp_d;
         led_q       <= led_d;
         led_valid_q <= led_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign led              = led_q;
   assign led_valid        = led_valid_q;
   assign game_pattern     = gp_q;
   assign done_gen_pattern = done_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player: table of requests, hand-written
// corner sequences and random requests against a cycle-timeline model.
module tb_pattern_player;

   logic        clk = 1'b0;
   logic        rst, clr, gen_pattern;
   logic [15:0] count;
   logic        led, led_valid, done_gen_pattern, busy;
   logic [15:0] game_pattern;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] m_lfsr, m_seq;

   pattern_player dut (
      .clk              (clk),
      .rst              (rst),
      .clr              (clr),
      .gen_pattern      (gen_pattern),
      .count            (count),
      .led              (led),
      .led_valid        (led_valid),
      .game_pattern     (game_pattern),
      .done_gen_pattern (done_gen_pattern),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] cnt;
      logic [15:0] gp;
      int          lat;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] m_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // expected {led_valid, led, busy, done} c cycles after acceptance
   function automatic logic [3:0] exp_ctl(input int c, input int len, input logic [15:0] seq);
      int j, pos;
      if (len == 0) return 4'b0001;
      if (c > len * 6) return 4'b0001;
      j   = (c - 1) / 6;
      pos = (c - 1) % 6;
      if (pos < 4) return {1'b1, seq[len - 1 - j], 1'b1, 1'b0};
      return 4'b0010;
   endfunction

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      m_lfsr = m_next(m_lfsr);
      m_seq  = m_lfsr;
   endtask

   task automatic run_request(input logic [15:0] cnt, input string nm,
                              output int lat, output logic [15:0] gp_seen);
      int          len, total;
      logic [15:0] mask;
      len   = (cnt > 16'd16) ? 16 : int'(cnt);
      mask  = (len == 16) ? 16'hFFFF : 16'((32'd1 << len) - 32'd1);
      count = cnt;
      gen_pattern = 1'b1;
      lat   = 0;
      total = len * 6 + 1;
      gp_seen = 16'd0;
      for (int c = 1; c <= total + 1; c++) begin
         step();
         if (c == 1) gp_seen = game_pattern;
         chk($sformatf("%s ctl c=%0d", nm, c),
             32'({led_valid, led, busy, done_gen_pattern}), 32'(exp_ctl(c, len, m_seq)));
         if (done_gen_pattern && lat == 0) lat = c;
      end
      chk({nm, " gp"}, 32'(game_pattern), 32'(m_seq & mask));
      gen_pattern = 1'b0;
      step();
      chk({nm, " done_fall"}, 32'({done_gen_pattern, busy, led_valid}), 32'd0);
   endtask

   initial begin
      int          lat;
      logic [15:0] gp;
      logic [15:0] cnt;

      tbl[0] = '{16'd3,  16'h0001, 19};
      tbl[1] = '{16'd0,  16'h0000, 1};
      tbl[2] = '{16'd20, 16'hACE1, 97};
      tbl[3] = '{16'd16, 16'hACE1, 97};
      tbl[4] = '{16'd1,  16'h0001, 7};
      tbl[5] = '{16'd5,  16'h0001, 31};
      tbl[6] = '{16'd8,  16'h00E1, 49};
      tbl[7] = '{16'd12, 16'h0CE1, 73};

      rst = 1'b1; clr = 1'b0; gen_pattern = 1'b0; count = 16'd0;
      m_lfsr = 16'hACE1; m_seq = 16'hACE1;
      step(); step();
      chk("reset outputs", 32'({led, led_valid, done_gen_pattern, busy, game_pattern}), 32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         run_request(tbl[i].cnt, $sformatf("tbl%0d", i), lat, gp);
         chk($sformatf("tbl%0d gp_const", i), 32'(gp), 32'(tbl[i].gp));
         chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      end

      // single clr then full-length round
      do_clr();
      run_request(16'd16, "clr16", lat, gp);
      chk("clr16 gp_const", 32'(gp), 32'h59C3);

      // clr and gen_pattern together: clr wins, request waits a cycle
      clr = 1'b1; gen_pattern = 1'b1; count = 16'd4;
      step();
      clr = 1'b0;
      m_lfsr = m_next(m_lfsr); m_seq = m_lfsr;
      chk("clr_vs_gen not accepted", 32'({led_valid, busy, done_gen_pattern}), 32'd0);
      run_request(16'd4, "after_clr", lat, gp);

      // abort during bit 2 ON window
      count = 16'd8; gen_pattern = 1'b1;
      for (int c = 1; c <= 14; c++) step();
      chk("abort pre led_valid", 32'({led_valid, busy}), 32'b11);
      gen_pattern = 1'b0;
      step();
      chk("abort outputs", 32'({led, led_valid, busy, done_gen_pattern}), 32'd0);
      chk("abort gp retained", 32'(game_pattern), 32'(m_seq & 16'h00FF));
      step(); step();
      chk("abort no done", 32'({done_gen_pattern, busy}), 32'd0);
      run_request(16'd8, "restart", lat, gp);

      // rst during OFF slot
      count = 16'd8; gen_pattern = 1'b1;
      for (int c = 1; c <= 5; c++) step();
      chk("in OFF", 32'({led_valid, busy}), 32'b01);
      rst = 1'b1; gen_pattern = 1'b0;
      step();
      chk("rst in OFF outputs", 32'({led, led_valid, done_gen_pattern, busy, game_pattern}), 32'd0);
      rst = 1'b0;
      m_lfsr = 16'hACE1; m_seq = 16'hACE1;
      run_request(16'd16, "post_rst", lat, gp);
      chk("post_rst seq is SEED", 32'(gp), 32'hACE1);
      do_clr();
      run_request(16'd16, "post_rst_clr", lat, gp);
      chk("post_rst lfsr is SEED", 32'(gp), 32'h59C3);

      // random requests with occasional reseeds
      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(0, 3) == 0) do_clr();
         cnt = 16'($urandom_range(0, 20));
         run_request(cnt, $sformatf("rnd%0d", r), lat, gp);
         chk($sformatf("rnd%0d latency", r), 32'(lat),
             32'(((cnt > 16'd16) ? 16 : int'(cnt)) * 6 + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pattern_player.md
# pattern_player

Presents the game's bit pattern to the player as timed LED pulses. It is the transmit side of the guess path: the input handler collects the player's serial bits, and this block emits the pattern those bits are compared against. It answers the classic-mode FSM's `gen_pattern` request with `done_gen_pattern`. It also drives `game_pattern` to the comparator, with bit alignment identical to the input handler's shift-in, so that first-presented = MSB of the active length.

## Interface
- `PATTERN_W`, default 16: maximum pattern length in bits.
- `ON_CYCLES`, default 4: cycles each bit is displayed; must be ≥1.
- `OFF_CYCLES`, default 2: blank cycles after each bit; must be ≥1.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clr` in 1: new game; reseeds the pattern.
- `gen_pattern` in 1: level request from the FSM, held until done.
- `count` in 16: number of bits to present this round.
- `led` out 1: presented bit value.
- `led_valid` out 1: high during ON slots.
- `game_pattern` out 16: expected guess, zero-extended.
- `done_gen_pattern` out 1: presentation complete.
- `busy` out 1: presentation in progress.

## Operation
- **Pattern source.**
  - 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  - Feedback: `fb = s[15]^s[13]^s[12]^s[10]`; next state = `{s[14:0], fb}`.
  - Register `seq` holds the round pattern.
  - On `clr`: LFSR steps once and `seq` loads the stepped value.
  - `seq` is unchanged between rounds, so successive rounds reuse the same sequence.
- **Length.** `len = min(count, PATTERN_W)`, latched on request acceptance.
- **States (`pattern_state_t`):**
  - IDLE:
    - `gen_pattern` with `len>0` → ON; latch `len`; set `idx = len-1`; `game_pattern <= seq & ((1<<len)-1)`.
    - `gen_pattern` with `len==0` → DONE; `game_pattern <= 0`.
  - ON: `led = seq[idx]`, `led_valid = 1`. After `ON_CYCLES` cycles → OFF.
  - OFF: `led = 0`, `led_valid = 0`. After `OFF_CYCLES` cycles:
    - `idx == 0` → DONE.
    - otherwise `idx--` → ON.
  - DONE: `done_gen_pattern = 1`. Exit to IDLE when `gen_pattern` is low.
- **Handshake.** Four-phase. A request is accepted only in IDLE. `done_gen_pattern` stays high until `gen_pattern` falls; it clears the cycle after that.
- **Outputs.** `busy` = state ∈ {ON, OFF}. All outputs are registered or decoded from the state register only, with no input-to-output combinational path.
- **Boundary conditions.**
  - `gen_pattern` drops in ON/OFF: abort to IDLE next cycle; `led` low; `game_pattern` retains its last value.
  - `clr` has priority over everything except `rst`: state → IDLE, timer cleared, LFSR steps, `seq` reloads.
  - `clr` and `gen_pattern` in the same cycle: `clr` wins and the request is not accepted that cycle.
  - `count > PATTERN_W`: clamp, no error.
  - Timer is wide enough for `max(ON_CYCLES, OFF_CYCLES)` and resets to 0 on every state entry.
- **Reset values.** `lfsr = seq = SEED`, state IDLE, `led = led_valid = done_gen_pattern = busy = 0`, `game_pattern = 0`, timer 0.

## Timing
- `gen_pattern` sampled high in IDLE at edge k: `led_valid` is high in cycle k+1.
- Bit j's ON window spans cycles `k+1+j*(ON+OFF)` to `k+j*(ON+OFF)+ON`.
- `done_gen_pattern` rises at cycle `k+1+len*(ON_CYCLES+OFF_CYCLES)`.
- With `len == 0`, `done_gen_pattern` rises at cycle k+1.
- `game_pattern` is valid from cycle k+1, before the first bit is shown.
- `clr` at edge k: new `seq` is visible at k+1.

## Structure
- `mem_pkg` holds:
  - `pattern_state_t` (IDLE, ON, OFF, DONE), 2-bit enum.
  - `LFSR_TAPS` constant.
  - `PATTERN_W` default shared with the comparator and input handler.
- Sub-module `lfsr16`: inputs `clk`, `rst`, `step`, parameter `SEED`; output `state[15:0]`. The FSM, timer and `idx` stay in `pattern_player`.

## Test plan
All scenarios use the defaults (`ON_CYCLES=4`, `OFF_CYCLES=2`, `SEED=16'hACE1`).
- **Reset, then `count=3`, `gen_pattern` held.** Required:
  - `game_pattern = 16'h0001`.
  - `led` shows 0,0,1, each for 4 cycles with `led_valid`, separated by 2 blank cycles.
  - `done_gen_pattern` rises 19 cycles after acceptance and falls the cycle after `gen_pattern` drops.
- **`count=0`.** `done_gen_pattern` is high the next cycle; `led_valid` never asserts; `game_pattern = 0`.
- **`count=20`.** Clamped to 16: `game_pattern = 16'hACE1`, 16 ON slots MSB-first (1,0,1,0,…), done after 97 cycles.
- **Single `clr` pulse, then `count=16`.** `game_pattern = 16'h59C3`.
- **`gen_pattern` dropped mid-presentation.** Drop during bit 2's ON window with `count=8`: next cycle state is IDLE, `led = led_valid = busy = 0`, no `done_gen_pattern`. A fresh request restarts from the MSB.
- **`rst` asserted during OFF.** All outputs return to reset values the next cycle; LFSR returns to `SEED`.
